// File: rtl/wb_write_queue.sv
// Writeback queue feeding the register file's single write port.
// In-order FIFO that drains one entry per granted cycle and forwards pending data to decode.
module wbq_match #(
  parameter int AW = 5
) (
  input  logic          vld_i,
  input  logic          block_i,
  input  logic [AW-1:0] ent_i,
  input  logic [AW-1:0] pr_i,
  output logic          hit_o
);
  assign hit_o = vld_i && !block_i && (ent_i == pr_i);
endmodule

module wb_write_queue #(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_wr,
  input  logic [31:0]              in_wd,
  input  logic                     drain_en,
  output logic                     write,
  output logic [4:0]               WR,
  output logic [31:0]              WD,
  input  logic [4:0]               PR1,
  input  logic [4:0]               PR2,
  output logic                     fwd1_hit,
  output logic [31:0]              fwd1_data,
  output logic                     fwd2_hit,
  output logic [31:0]              fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][4:0]  wr_q;
  logic [DEPTH-1:0][31:0] wd_q;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   push, pop, drop;
  logic [DEPTH-1:0]       vld, hit1, hit2;

  // r0 writes complete the handshake but never occupy a slot
  assign drop     = DROP_R0 && (in_wr == 5'd0);
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready && !drop;
  assign write    = (count_q != '0) && drain_en;
  assign pop      = write;
  assign WR       = (count_q != '0) ? wr_q[head_q] : 5'd0;
  assign WD       = (count_q != '0) ? wd_q[head_q] : 32'd0;
  assign count    = count_q;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      wd_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_q[tail_q] <= in_wr;
        wd_q[tail_q] <= in_wd;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // An entry is live when its distance from head is below count
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] age;
    assign age    = PW'(i) - head_q;
    assign vld[i] = ({1'b0, age} < count_q);
    wbq_match #(.AW(5)) u_m1 (
      .vld_i(vld[i]), .block_i(DROP_R0 && (PR1 == 5'd0)),
      .ent_i(wr_q[i]), .pr_i(PR1), .hit_o(hit1[i]));
    wbq_match #(.AW(5)) u_m2 (
      .vld_i(vld[i]), .block_i(DROP_R0 && (PR2 == 5'd0)),
      .ent_i(wr_q[i]), .pr_i(PR2), .hit_o(hit2[i]));
  end

  // Walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (hit1[idx]) begin
        fwd1_hit  = 1'b1;
        fwd1_data = wd_q[idx];
      end
      if (hit2[idx]) begin
        fwd2_hit  = 1'b1;
        fwd2_data = wd_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: handshake, drain order, forwarding, r0 drop, async reset.
module tb_wb_write_queue;
  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_wr;
  logic [31:0] in_wd;
  logic        drain_en, write;
  logic [4:0]  WR, PR1, PR2;
  logic [31:0] WD, fwd1_data, fwd2_data;
  logic        fwd1_hit, fwd2_hit;
  logic [2:0]  count;

  int ncmp = 0;
  int nfail = 0;

  wb_write_queue #(.DEPTH(4), .DROP_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_wr(in_wr), .in_wd(in_wd), .drain_en(drain_en), .write(write),
    .WR(WR), .WD(WD), .PR1(PR1), .PR2(PR2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data), .count(count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1'b1; in_wr = r; in_wd = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_wr = '0; in_wd = '0;
    drain_en = 1'b1; PR1 = '0; PR2 = '0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_write", write, 0);
    chk("rst_WR", WR, 0);
    chk("rst_WD", WD, 0);
    chk("rst_fwd1", fwd1_hit, 0);
    chk("rst_fwd2_data", fwd2_data, 0);
    #9 rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);

    // 1: single push, drain next cycle
    in_valid = 1'b1; in_wr = 5'd4; in_wd = 32'd31; PR1 = 5'd4;
    #1;
    chk("t1_nohit_same_cycle", fwd1_hit, 0);
    chk("t1_write_pre", write, 0);
    tick();
    in_valid = 1'b0;
    chk("t1_write", write, 1);
    chk("t1_WR", WR, 4);
    chk("t1_WD", WD, 31);
    chk("t1_count", count, 1);
    chk("t1_fwd_hit", fwd1_hit, 1);
    chk("t1_fwd_data", fwd1_data, 31);
    tick();
    chk("t1_write_after", write, 0);
    chk("t1_count_after", count, 0);

    // 2: fill with drain held
    drain_en = 1'b0;
    push(5'd5, 32'd1);
    push(5'd6, 32'd2);
    push(5'd5, 32'd3);
    push(5'd7, 32'd4);
    chk("t2_count", count, 4);
    chk("t2_ready", in_ready, 0);
    chk("t2_write_held", write, 0);
    PR1 = 5'd5; PR2 = 5'd8;
    #1;
    chk("t2_fwd1_hit", fwd1_hit, 1);
    chk("t2_fwd1_young", fwd1_data, 3);
    chk("t2_fwd2_hit", fwd2_hit, 0);
    chk("t2_fwd2_data", fwd2_data, 0);
    PR2 = 5'd6;
    #1;
    chk("t2_fwd2_r6", fwd2_data, 2);
    push(5'd9, 32'd99);
    chk("t2_full_reject", count, 4);

    // 3: drain in order; popped head still forwards that cycle
    drain_en = 1'b1;
    #1;
    chk("t3_write", write, 1);
    chk("t3_WR0", WR, 5);
    chk("t3_WD0", WD, 1);
    chk("t3_head_fwd", fwd1_data, 3);
    tick();
    chk("t3_ready", in_ready, 1);
    chk("t3_WR1", WR, 6);
    chk("t3_WD1", WD, 2);
    tick();
    chk("t3_WR2", WR, 5);
    chk("t3_WD2", WD, 3);
    tick();
    chk("t3_WR3", WR, 7);
    chk("t3_WD3", WD, 4);
    tick();
    chk("t3_count0", count, 0);
    chk("t3_write0", write, 0);

    // 4: streaming push/pop across pointer wrap
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_wr = 5'(i); in_wd = 32'(100 + i);
      tick();
      chk("t4_count", count, 1);
      chk("t4_write", write, 1);
      chk("t4_WR", WR, 32'(i));
      chk("t4_WD", WD, 32'(100 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("t4_count_end", count, 0);

    // 5: r0 write is swallowed
    in_valid = 1'b1; in_wr = 5'd0; in_wd = 32'd55; PR1 = 5'd0;
    #1;
    chk("t5_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t5_count", count, 0);
    chk("t5_write", write, 0);
    chk("t5_fwd_r0", fwd1_hit, 0);
    tick();
    chk("t5_write_later", write, 0);

    // 6: async reset mid-cycle with 3 queued entries
    drain_en = 1'b0;
    push(5'd9, 32'd9);
    push(5'd10, 32'd10);
    push(5'd11, 32'd11);
    drain_en = 1'b1; PR1 = 5'd9;
    #1;
    chk("t6_write_pre", write, 1);
    chk("t6_fwd_pre", fwd1_hit, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_write_rst", write, 0);
    chk("t6_count_rst", count, 0);
    chk("t6_fwd_rst", fwd1_hit, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("t6_count_post", count, 0);
    chk("t6_write_post", write, 0);
    chk("t6_WR_post", WR, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
